// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit for the EX stage.
// Owns the HI/LO registers. A multiply uses shift-add and a divide uses
// restoring division. Both take DATA_W iterations. Signed operations run on
// operand magnitudes, and the sign fixup is applied on the last iteration.
// A divide by zero skips the iteration and completes on the next cycle.
// Optional macro MULDIV_EARLY_OUT_EN: a multiply finishes as soon as the
// remaining multiplier bits are all zero.
module ex_muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              flush,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0]    cnt_reg;
    logic                is_div_reg;
    logic                neg_res_reg;   // negate product / quotient
    logic                neg_rem_reg;   // negate remainder (dividend sign)
    logic                dbz_reg;
    logic [2*DATA_W-1:0] mcand_reg;     // multiplicand, shifted left per step
    logic [DATA_W-1:0]   mplier_reg;    // multiplier, shifted right per step
    logic [2*DATA_W-1:0] prod_reg;
    logic [DATA_W-1:0]   rem_reg;
    logic [DATA_W-1:0]   quot_reg;      // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0]   divisor_reg;
    logic [DATA_W-1:0]   hi_reg;
    logic [DATA_W-1:0]   lo_reg;

    // Operand decode. Signed ops take magnitudes. The magnitude of the most
    // negative value is still correct when it is read as unsigned.
    logic              op_signed;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic              zero_div;
    logic              accept;

    assign op_signed = ~op[0];
    assign a_neg     = op_signed & rs_val[DATA_W-1];
    assign b_neg     = op_signed & rt_val[DATA_W-1];
    assign a_mag     = a_neg ? ('0 - rs_val) : rs_val;
    assign b_mag     = b_neg ? ('0 - rt_val) : rt_val;
    assign zero_div  = op[1] && (rt_val == '0);
    assign accept    = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

    // One iteration step for each datapath.
    logic [2*DATA_W-1:0] prod_step;
    logic [DATA_W-1:0]   mplier_step;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W:0]     rem_trial;
    logic                q_bit;
    logic [DATA_W-1:0]   rem_step;
    logic [DATA_W-1:0]   quot_step;
    logic                last_iter;

    assign prod_step   = mplier_reg[0] ? (prod_reg + mcand_reg) : prod_reg;
    assign mplier_step = mplier_reg >> 1;
    assign rem_shift   = {rem_reg, quot_reg[DATA_W-1]};
    assign rem_trial   = rem_shift - {1'b0, divisor_reg};
    assign q_bit       = ~rem_trial[DATA_W];
    assign rem_step    = q_bit ? rem_trial[DATA_W-1:0] : rem_shift[DATA_W-1:0];
    assign quot_step   = {quot_reg[DATA_W-2:0], q_bit};

`ifdef MULDIV_EARLY_OUT_EN
    assign last_iter = (cnt_reg == CNT_W'(1)) || (!is_div_reg && (mplier_step == '0));
`else
    assign last_iter = (cnt_reg == CNT_W'(1));
`endif

    // Sign fixup applied to the values from the final iteration.
    logic [2*DATA_W-1:0] prod_fin;
    logic [DATA_W-1:0]   quot_fin;
    logic [DATA_W-1:0]   rem_fin;
    logic [DATA_W-1:0]   hi_fin;
    logic [DATA_W-1:0]   lo_fin;

    assign prod_fin = neg_res_reg ? ('0 - prod_step) : prod_step;
    assign quot_fin = neg_res_reg ? ('0 - quot_step) : quot_step;
    assign rem_fin  = neg_rem_reg ? ('0 - rem_step)  : rem_step;
    assign hi_fin   = is_div_reg ? rem_fin  : prod_fin[2*DATA_W-1:DATA_W];
    assign lo_fin   = is_div_reg ? quot_fin : prod_fin[DATA_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. flush overrides start.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start) state_next = zero_div ? S_DONE : S_BUSY;
            S_BUSY: if (last_iter) state_next = S_DONE;
            S_DONE: begin
                if (start) state_next = zero_div ? S_DONE : S_BUSY;
                else       state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    // Datapath: latch operands on accept and iterate while busy.
    // HI/LO commit on the final iteration, or directly on a divide by zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            dbz_reg     <= 1'b0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            prod_reg    <= '0;
            rem_reg     <= '0;
            quot_reg    <= '0;
            divisor_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else if (!flush) begin
            if (accept) begin
                cnt_reg     <= CNT_W'(DATA_W);
                is_div_reg  <= op[1];
                neg_res_reg <= a_neg ^ b_neg;
                neg_rem_reg <= a_neg;
                dbz_reg     <= zero_div;
                mcand_reg   <= {{DATA_W{1'b0}}, a_mag};
                mplier_reg  <= b_mag;
                prod_reg    <= '0;
                rem_reg     <= '0;
                quot_reg    <= a_mag;
                divisor_reg <= b_mag;
                if (zero_div) begin
                    hi_reg <= rs_val;
                    lo_reg <= '1;
                end
            end else if (state_reg == S_BUSY) begin
                cnt_reg    <= cnt_reg - CNT_W'(1);
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_step;
                prod_reg   <= prod_step;
                rem_reg    <= rem_step;
                quot_reg   <= quot_step;
                if (last_iter) begin
                    hi_reg <= hi_fin;
                    lo_reg <= lo_fin;
                end
            end
        end
    end

    assign busy        = (state_reg == S_BUSY);
    assign done        = (state_reg == S_DONE);
    assign div_by_zero = (state_reg == S_DONE) && dbz_reg;
    assign stall       = (start && (state_reg == S_IDLE)) || busy;
    assign hi          = hi_reg;
    assign lo          = lo_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: table-driven vectors for ex_muldiv_unit, followed by
// hand-written back-to-back, flush and reset sequences.
module tb_ex_muldiv_unit;

    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              flush;
    logic              stall;
    logic              busy;
    logic              done;
    logic              div_by_zero;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    ex_muldiv_unit #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] exp_hi;
        logic [DATA_W-1:0] exp_lo;
        logic              exp_dbz;
        int                exp_lat;
    } vec_t;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    vec_t vecs[12];

    // Starts one op in an IDLE cycle (cycle 0) and waits for done.
    // It returns the done cycle (0 means timeout) and the number of cycles
    // where stall/busy were wrong.
    task automatic run_op(input logic [1:0] o, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          output int lat, output int stall_bad);
        @(posedge clk); #1;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        stall_bad = (stall !== 1'b1) ? 1 : 0;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                if (stall !== 1'b0 || busy !== 1'b0) stall_bad++;
                break;
            end
            if (stall !== 1'b1 || busy !== 1'b1) stall_bad++;
        end
    endtask

    initial begin
        int lat;
        int sbad;
        int seen_done;
        int seen_busy;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[4]  = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, 1};
        vecs[5]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 33};
        vecs[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
        vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
        vecs[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1};
        vecs[9]  = '{OP_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 33};
        vecs[10] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33};
        vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 33};

        rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_hi", 64'(hi), 64'h0);
        chk("reset_lo", 64'(lo), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_dbz", 64'(div_by_zero), 64'h0);
        chk("reset_stall", 64'(stall), 64'h0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, sbad);
            $display("vec %0d op=%0d a=%h b=%h -> lat=%0d hi=%h lo=%h dbz=%0b",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, lat, hi, lo, div_by_zero);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            chk($sformatf("vec%0d_dbz", i), 64'(div_by_zero), 64'(vecs[i].exp_dbz));
            chk($sformatf("vec%0d_stall_window", i), 64'(sbad), 64'h0);
        end

        // Back-to-back: start in the DONE cycle. A stray start during BUSY
        // is ignored.
        run_op(OP_MULTU, 32'd3, 32'd4, lat, sbad);
        chk("b2b_first_lo", 64'(lo), 64'd12);
        start = 1'b1; op = OP_MULTU; rs_val = 32'd5; rt_val = 32'd6;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            start = (k == 5);
            rs_val = (k == 5) ? 32'd9 : 32'd5;
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        $display("b2b MULTU 5x6 -> lat=%0d hi=%h lo=%h", lat, hi, lo);
        chk("b2b_latency", 64'(lat), 64'd33);
        chk("b2b_hi", 64'(hi), 64'd0);
        chk("b2b_lo", 64'(lo), 64'd30);

        // Preload HI/LO = 0x11/0x22 with DIVU 0x2211 / 0x100.
        run_op(OP_DIVU, 32'h2211, 32'h100, lat, sbad);
        chk("preload_hi", 64'(hi), 64'h11);
        chk("preload_lo", 64'(lo), 64'h22);

        // Flush at cycle 10 of MULTU 3x4.
        @(posedge clk); #1;
        start = 1'b1; op = OP_MULTU; rs_val = 32'd3; rt_val = 32'd4;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 10) flush = 1'b1;
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        $display("flush at cycle 10 -> busy=%0b done=%0b hi=%h lo=%h", busy, done, hi, lo);
        chk("flush_busy", 64'(busy), 64'h0);
        chk("flush_hi", 64'(hi), 64'h11);
        chk("flush_lo", 64'(lo), 64'h22);
        seen_done = 0; seen_busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
            if (busy === 1'b1) seen_busy++;
        end
        chk("flush_no_done", 64'(seen_done), 64'h0);
        chk("flush_stays_idle", 64'(seen_busy), 64'h0);
        chk("flush_hi_after", 64'(hi), 64'h11);

        // Reset at cycle 10 of MULTU 3x4.
        @(posedge clk); #1;
        start = 1'b1; op = OP_MULTU; rs_val = 32'd3; rt_val = 32'd4;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 10) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        $display("rst at cycle 10 -> busy=%0b done=%0b hi=%h lo=%h", busy, done, hi, lo);
        chk("rst_mid_busy", 64'(busy), 64'h0);
        chk("rst_mid_hi", 64'(hi), 64'h0);
        chk("rst_mid_lo", 64'(lo), 64'h0);
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        chk("rst_mid_no_done", 64'(seen_done), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
